// File: rtl/adder_tree_sum.sv
// Pipelined signed multi-operand adder for the FFT datapath.
// NUM operands of W bits are summed at full precision through a registered
// binary tree. The sum is then optionally scaled by a rounded arithmetic right
// shift and saturated or wrapped back to W bits. Valid and shift travel in
// lock-step with the data, and i_ce stalls every register.
module adder_tree_sum #(
  parameter int W         = 16,
  parameter int NUM       = 3,
  parameter int MAX_SHIFT = 4,
  parameter int SAT       = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ce,
  input  logic                 i_valid,
  input  logic [NUM*W-1:0]     i_data,
  input  logic [2:0]           i_shift,
  output logic                 o_valid,
  output logic signed [W-1:0]  o_sum,
  output logic                 o_ovf
);

  // Number of nodes present at tree level j (level 0 = the raw operands).
  function automatic int lvl_cnt(input int j);
    int n;
    n = NUM;
    for (int k = 0; k < j; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // Index of the first node of level j in the flattened node list.
  function automatic int lvl_off(input int j);
    int o;
    o = 0;
    for (int k = 0; k < j; k++) o += lvl_cnt(k);
    return o;
  endfunction

  localparam int L    = $clog2(NUM);
  localparam int GW   = W + L;
  localparam int TOT  = lvl_off(L + 1);
  localparam int NREG = TOT - NUM;
  localparam logic [2:0] MS = 3'(MAX_SHIFT);

  if (NUM < 2 || NUM > 8 || MAX_SHIFT < 0 || MAX_SHIFT > 7) begin : g_bad_param
    $error("adder_tree_sum: NUM must be 2..8 and MAX_SHIFT 0..7");
  end

  // Rounded (half up) arithmetic right shift, evaluated one bit wider than
  // the tree so the rounding bias can never overflow.
  function automatic logic signed [GW:0] round_shift(input logic signed [GW-1:0] x,
                                                     input logic [2:0] s);
    logic signed [GW:0] xe;
    logic signed [GW:0] bias;
    xe   = (GW+1)'(x);
    bias = ((GW+1)'(1) << s) >> 1;
    return (xe + bias) >>> s;
  endfunction

  // Reduce to W bits: returns {overflow, value}. Out-of-range results clamp
  // to the nearest extreme when SAT=1, otherwise keep the low W bits.
  function automatic logic [W:0] clip(input logic signed [GW:0] r);
    logic fits;
    fits = (r[GW:W-1] == {(GW-W+2){r[W-1]}});
    if (fits || SAT == 0) return {~fits, r[W-1:0]};
    return {1'b1, (r[GW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})};
  endfunction

  logic signed [GW-1:0] node   [TOT];
  logic signed [GW-1:0] tree_p [NREG];
  logic [L-1:0]         vld_p;
  logic [2:0]           shf_p  [L];
  logic [2:0]           sh_in;
  logic signed [GW:0]   rnd;
  logic [W:0]           fin;

  assign sh_in = (i_shift > MS) ? MS : i_shift;

  // Flatten sign-extended operands and registered tree levels into one list.
  always_comb begin
    for (int k = 0; k < NUM; k++) node[k] = GW'($signed(i_data[k*W +: W]));
    for (int k = 0; k < NREG; k++) node[NUM+k] = tree_p[k];
  end

  // ---- tree levels 1..L: pairwise adds, odd leftover registered as-is ----
  for (genvar j = 1; j <= L; j++) begin : g_lvl
    for (genvar i = 0; i < lvl_cnt(j); i++) begin : g_node
      localparam int SRC = lvl_off(j-1) + 2*i;
      localparam int DST = lvl_off(j) - NUM + i;
      if (2*i + 1 < lvl_cnt(j-1)) begin : g_add
        // Sum of an adjacent pair from the previous level.
        always_ff @(posedge i_clk or negedge i_rst_n)
          if (!i_rst_n)  tree_p[DST] <= '0;
          else if (i_ce) tree_p[DST] <= node[SRC] + node[SRC+1];
      end else begin : g_pass
        // Unpaired node delayed one level to keep all paths equal.
        always_ff @(posedge i_clk or negedge i_rst_n)
          if (!i_rst_n)  tree_p[DST] <= '0;
          else if (i_ce) tree_p[DST] <= node[SRC];
      end
    end
  end

  // Valid flag and clamped shift follow the data through the tree levels.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      vld_p <= '0;
      for (int k = 0; k < L; k++) shf_p[k] <= '0;
    end else if (i_ce) begin
      vld_p[0] <= i_valid;
      shf_p[0] <= sh_in;
      for (int k = 1; k < L; k++) begin
        vld_p[k] <= vld_p[k-1];
        shf_p[k] <= shf_p[k-1];
      end
    end

  // ---- final stage: scale, saturate/wrap, register outputs ----
  assign rnd = round_shift(node[TOT-1], shf_p[L-1]);
  assign fin = clip(rnd);

  // Output register; holds the presented sample across a stall.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_ovf   <= 1'b0;
    end else if (i_ce) begin
      o_valid <= vld_p[L-1];
      o_sum   <= fin[W-1:0];
      o_ovf   <= fin[W];
    end

endmodule

// File: tb/tb_adder_tree_sum.sv
// Bench for adder_tree_sum: directed cases plus a randomized stream checked
// against an arithmetic reference model, across NUM=2/3/8 and SAT=0/1.
module tb_adder_tree_sum;
  localparam int W  = 16;
  localparam int MS = 4;

  logic i_clk = 1'b0;
  logic clk_en = 1'b0;
  logic i_rst_n, i_ce, i_valid;
  logic [2:0] i_shift;
  logic [3*W-1:0] d3;
  logic [2*W-1:0] d2;
  logic [8*W-1:0] d8;
  logic v3s, v3w, v2, v8, f3s, f3w, f2, f8;
  logic signed [W-1:0] s3s, s3w, s2, s8;

  int total = 0;
  int bad   = 0;

  adder_tree_sum #(.W(W), .NUM(3), .MAX_SHIFT(MS), .SAT(1)) u_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_valid(i_valid), .i_data(d3),
    .i_shift(i_shift), .o_valid(v3s), .o_sum(s3s), .o_ovf(f3s));
  adder_tree_sum #(.W(W), .NUM(3), .MAX_SHIFT(MS), .SAT(0)) u_wrap (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_valid(i_valid), .i_data(d3),
    .i_shift(i_shift), .o_valid(v3w), .o_sum(s3w), .o_ovf(f3w));
  adder_tree_sum #(.W(W), .NUM(2), .MAX_SHIFT(MS), .SAT(1)) u_n2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_valid(i_valid), .i_data(d2),
    .i_shift(i_shift), .o_valid(v2), .o_sum(s2), .o_ovf(f2));
  adder_tree_sum #(.W(W), .NUM(8), .MAX_SHIFT(MS), .SAT(1)) u_n8 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_valid(i_valid), .i_data(d8),
    .i_shift(i_shift), .o_valid(v8), .o_sum(s8), .o_ovf(f8));

  always begin
    #5;
    if (clk_en) i_clk = ~i_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: full-precision sum, clamp shift, round half up, then fit to W.
  function automatic void model(input longint sum, input int sh, input int sat,
                                output longint res, output bit ovf);
    int s;
    longint r, w;
    s = (sh > MS) ? MS : sh;
    r = (s > 0) ? ((sum + (64'sd1 <<< (s - 1))) >>> s) : sum;
    ovf = (r > 32767) || (r < -32768);
    if (!ovf)      res = r;
    else if (sat != 0) res = (r > 0) ? 32767 : -32768;
    else begin
      w = r & 65535;
      if (w > 32767) w -= 65536;
      res = w;
    end
  endfunction

  // ---- single-pulse capture for all four instances ----
  int lat[4];
  int vc[4];
  logic signed [63:0] sm[4];
  logic ov[4];

  function automatic void grab(input int k, input int n, input logic v,
                               input logic signed [W-1:0] s, input logic f);
    if (v === 1'b1) begin
      vc[k]++;
      if (lat[k] < 0) begin
        lat[k] = n;
        sm[k]  = 64'(s);
        ov[k]  = f;
      end
    end
  endfunction

  task automatic pulse();
    for (int k = 0; k < 4; k++) begin lat[k] = -1; vc[k] = 0; end
    i_ce = 1'b1;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      grab(0, n, v3s, s3s, f3s);
      grab(1, n, v3w, s3w, f3w);
      grab(2, n, v2, s2, f2);
      grab(3, n, v8, s8, f8);
      if (n < 8) @(negedge i_clk);
    end
  endtask

  task automatic chk_pulse(input string tag, input int k, input int el, input longint es, input bit eo);
    chk({tag, "_lat"}, lat[k], el);
    chk({tag, "_vcnt"}, vc[k], 1);
    chk({tag, "_sum"}, sm[k], es);
    chk({tag, "_ovf"}, ov[k], eo);
  endtask

  task automatic dir3(input string tag, input int a, input int b, input int c, input int sh,
                      input longint es, input bit eo, input longint ew, input bit ewo);
    d3 = {16'(c), 16'(b), 16'(a)};
    i_shift = 3'(sh);
    pulse();
    chk_pulse({tag, "_sat"}, 0, 3, es, eo);
    chk_pulse({tag, "_wrap"}, 1, 3, ew, ewo);
  endtask

  // ---- streaming with a scoreboard ----
  typedef struct { longint s; bit o; } exp_t;
  exp_t qs[$];
  exp_t qw[$];
  int edge_n, first_edge, last_edge, pops;
  logic lv_s, lo_s, lv_w;
  logic signed [W-1:0] ls_s, ls_w;

  task automatic snap();
    lv_s = v3s; ls_s = s3s; lo_s = f3s;
    lv_w = v3w; ls_w = s3w;
  endtask

  task automatic cyc(input bit v, input int a, input int b, input int c, input int sh, input bit ce);
    exp_t e;
    longint ms;
    bit mo;
    i_valid = v;
    i_ce    = ce;
    i_shift = 3'(sh);
    d3      = {16'(c), 16'(b), 16'(a)};
    @(negedge i_clk);
    edge_n++;
    if (ce && v) begin
      model(longint'(a) + b + c, sh, 1, ms, mo);
      e.s = ms; e.o = mo; qs.push_back(e);
      model(longint'(a) + b + c, sh, 0, ms, mo);
      e.s = ms; e.o = mo; qw.push_back(e);
      if (first_edge < 0) first_edge = edge_n;
    end
    if (ce) begin
      if (v3s === 1'b1) begin
        if (qs.size() == 0) chk("sat_spurious_valid", 1, 0);
        else begin
          e = qs.pop_front();
          chk("str_sat_sum", s3s, e.s);
          chk("str_sat_ovf", f3s, e.o);
          pops++;
          last_edge = edge_n;
        end
      end
      if (v3w === 1'b1) begin
        if (qw.size() == 0) chk("wrap_spurious_valid", 1, 0);
        else begin
          e = qw.pop_front();
          chk("str_wrap_sum", s3w, e.s);
          chk("str_wrap_ovf", f3w, e.o);
        end
      end
    end else begin
      chk("hold_vld", v3s, lv_s);
      chk("hold_vld_w", v3w, lv_w);
      if (lv_s) begin
        chk("hold_sum", s3s, ls_s);
        chk("hold_ovf", f3s, lo_s);
      end
      if (lv_w) chk("hold_sum_w", s3w, ls_w);
    end
    snap();
  endtask

  int nv;
  logic signed [15:0] ra, rb, rc;

  initial begin
    i_rst_n = 1'b1; i_ce = 1'b0; i_valid = 1'b0; i_shift = '0;
    d3 = '0; d2 = '0; d8 = '0;

    // Asynchronous reset with the clock stopped.
    #3 i_rst_n = 1'b0;
    #1;
    chk("rst_vld", v3s, 0);
    chk("rst_sum", s3s, 0);
    chk("rst_ovf", f3s, 0);
    chk("rst_vld_w", v3w, 0);
    chk("rst_vld_n2", v2, 0);
    chk("rst_vld_n8", v8, 0);
    clk_en = 1'b1;
    repeat (2) @(negedge i_clk);

    // Release with i_ce low: pipeline must stay empty.
    i_rst_n = 1'b1; i_valid = 1'b1; d3 = {3{16'sd5}};
    nv = 0;
    repeat (3) begin @(negedge i_clk); if (v3s !== 1'b0) nv++; end
    i_valid = 1'b0; i_ce = 1'b1;
    repeat (5) begin @(negedge i_clk); if (v3s !== 1'b0 || v8 !== 1'b0) nv++; end
    chk("release_ce0_empty", nv, 0);

    // Basic sum on all instances.
    d2 = {-16'sd50, 16'sd100};
    d8 = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'sd7, -16'sd50, 16'sd100};
    dir3("basic", 100, -50, 7, 0, 57, 0, 57, 0);
    chk_pulse("basic_n2", 2, 2, 50, 0);
    chk_pulse("basic_n8", 3, 4, 57, 0);

    // Overflow, rounding and shift clamp.
    dir3("ovf_pos", 32767, 32767, 32767, 0, 32767, 1, 32765, 1);
    dir3("ovf_neg", -32768, -32768, 0, 0, -32768, 1, 0, 1);
    dir3("rnd_pos", 3, 0, 0, 1, 2, 0, 2, 0);
    dir3("rnd_neg", -3, 0, 0, 1, -1, 0, -1, 0);
    dir3("shift2", 32767, 32767, 32767, 2, 24575, 0, 24575, 0);
    dir3("shift_clamp", 16, 0, 0, 7, 1, 0, 1, 0);

    // Eight equal operands scaled by 8; NUM=2 with rounding at shift 3.
    d8 = {8{16'sd4096}};
    d2 = {16'sd1000, 16'sd24};
    d3 = '0;
    i_shift = 3'd3;
    pulse();
    chk_pulse("n8_scale", 3, 4, 4096, 0);
    chk_pulse("n2_scale", 2, 2, 128, 0);

    // Reset pulse with two samples in flight.
    d3 = {3{16'sd9}};
    i_shift = 3'd0; i_ce = 1'b1; i_valid = 1'b1;
    repeat (2) @(negedge i_clk);
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_vld", v3s, 0);
    chk("midrst_sum", s3s, 0);
    #1 i_rst_n = 1'b1;
    nv = 0;
    repeat (8) begin
      @(negedge i_clk);
      if (v3s !== 1'b0 || v3w !== 1'b0 || v2 !== 1'b0 || v8 !== 1'b0) nv++;
    end
    chk("midrst_no_valid", nv, 0);

    // Stream of four with a two-cycle stall after the second sample.
    snap();
    edge_n = 0; first_edge = -1; last_edge = -1; pops = 0;
    cyc(1, 1, 1, 1, 0, 1);
    cyc(1, 2, 2, 2, 0, 1);
    cyc(1, 9, 9, 9, 0, 0);
    cyc(1, 9, 9, 9, 0, 0);
    cyc(1, 3, 3, 3, 0, 1);
    cyc(1, 4, 4, 4, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 1);
    chk("stall_pops", pops, 4);
    chk("stall_cycles", last_edge - first_edge + 1, 8);

    // Randomized stream with random stalls and shifts.
    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin ra = 16'sh7fff; rb = 16'sh7fff; end
      cyc($urandom_range(0, 9) < 7, ra, rb, rc, $urandom_range(0, 7), $urandom_range(0, 9) < 8);
    end
    repeat (6) cyc(0, 0, 0, 0, 0, 1);
    chk("drain_sat", qs.size(), 0);
    chk("drain_wrap", qw.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
